// File: rtl/pg_fault_ctrl.sv
// Mesh fault/power-gate controller: drains the network, gates one node, and ungates it on a matching request.
// All outputs are registered; requests are taken only in IDLE and GATED.
module pg_fault_ctrl #(
  parameter int MESH_W        = 4,
  parameter int MESH_H        = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int WAKE_CYCLES   = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_gate,
  input  logic [5:0] req_node,
  input  logic       net_idle,
  output logic       pg_en,
  output logic [5:0] pg_node,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, DRAIN, SETTLE, GATED, WAKE} state_t;

  localparam logic [3:0] MESH_W_L   = 4'(MESH_W);
  localparam logic [3:0] MESH_H_L   = 4'(MESH_H);
  localparam logic [7:0] SETTLE_N   = 8'(SETTLE_CYCLES);
  localparam logic [7:0] WAKE_N     = 8'(WAKE_CYCLES);
  localparam logic [7:0] TIMEOUT_LM = 8'(DRAIN_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] node_q, node_d;
  logic       pg_en_d, done_d, err_d, ready_d, busy_d;
  logic [5:0] pg_node_d;
  logic       xfer, in_range;

  assign xfer     = req_valid && req_ready;
  assign in_range = ({1'b0, req_node[2:0]} < MESH_W_L) && ({1'b0, req_node[5:3]} < MESH_H_L);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    node_d    = node_q;
    pg_en_d   = pg_en;
    pg_node_d = pg_node;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (req_gate && in_range) begin
            node_d  = req_node;
            cnt_d   = 8'd0;
            state_d = DRAIN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (net_idle) begin
          pg_en_d   = 1'b1;
          pg_node_d = node_q;
          cnt_d     = SETTLE_N;
          state_d   = SETTLE;
        end else if (cnt_q == TIMEOUT_LM) begin
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          node_d  = 6'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Counter loaded with N terminates on the edge where it holds 1, i.e. N cycles after load.
      SETTLE: begin
        if (cnt_q <= 8'd1) begin
          done_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = GATED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GATED: begin
        if (xfer) begin
          if (!req_gate && (req_node == pg_node)) begin
            pg_en_d   = 1'b0;
            pg_node_d = 6'd0;
            node_d    = 6'd0;
            cnt_d     = WAKE_N;
            state_d   = WAKE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAKE: begin
        if (cnt_q <= 8'd1) begin
          done_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        node_d    = 6'd0;
        pg_en_d   = 1'b0;
        pg_node_d = 6'd0;
      end
    endcase
    ready_d = (state_d == IDLE) || (state_d == GATED);
    busy_d  = (state_d == DRAIN) || (state_d == SETTLE) || (state_d == WAKE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      node_q    <= 6'd0;
      pg_en     <= 1'b0;
      pg_node   <= 6'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      node_q    <= node_d;
      pg_en     <= pg_en_d;
      pg_node   <= pg_node_d;
      done      <= done_d;
      err       <= err_d;
      req_ready <= ready_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_pg_fault_ctrl.sv
// Directed bench for pg_fault_ctrl: a cycle-by-cycle vector table for the gate/ungate flow
// plus hand sequences for range errors, drain timeout and asynchronous reset.
module tb_pg_fault_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_gate = 1'b0;
  logic [5:0] req_node = 6'd0;
  logic       net_idle = 1'b0;
  logic       req_ready, pg_en, busy, done, err;
  logic [5:0] pg_node;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v, g;
    logic [5:0] n;
    logic       idle;
    logic       pe;
    logic [5:0] pn;
    logic       dn, er, rd, bs;
  } vec_t;

  vec_t vecs[$];

  pg_fault_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_gate(req_gate), .req_node(req_node), .net_idle(net_idle),
    .pg_en(pg_en), .pg_node(pg_node), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic v, g, input logic [5:0] n, input logic idle,
                     input logic pe, input logic [5:0] pn, input logic dn, er, rd, bs);
    vec_t t;
    t.v = v; t.g = g; t.n = n; t.idle = idle;
    t.pe = pe; t.pn = pn; t.dn = dn; t.er = er; t.rd = rd; t.bs = bs;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pe, input logic [5:0] pn,
                         input logic dn, er, rd, bs);
    chk({tag, ".pg_en"},     32'(pg_en),     32'(pe));
    chk({tag, ".pg_node"},   32'(pg_node),   32'(pn));
    chk({tag, ".done"},      32'(done),      32'(dn));
    chk({tag, ".err"},       32'(err),       32'(er));
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rd));
    chk({tag, ".busy"},      32'(busy),      32'(bs));
  endtask

  task automatic drive(input logic v, g, input logic [5:0] n, input logic idle);
    req_valid = v; req_gate = g; req_node = n; net_idle = idle;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: valid, gate, node, net_idle | pg_en, pg_node, done, err, ready, busy
    add(1, 1, 6'h1A, 1,  0, 6'h00, 0, 0, 0, 1);   // accept -> DRAIN
    add(0, 0, 6'h00, 1,  1, 6'h1A, 0, 0, 0, 1);   // idle seen -> SETTLE
    for (int i = 0; i < 3; i++)
      add(1, 0, 6'h1A, 0,  1, 6'h1A, 0, 0, 0, 1); // held request and net_idle ignored
    add(0, 0, 6'h00, 0,  1, 6'h1A, 1, 0, 1, 0);   // done 4 cycles after pg_en rose
    add(0, 0, 6'h00, 0,  1, 6'h1A, 0, 0, 1, 0);
    add(1, 0, 6'h09, 0,  1, 6'h1A, 0, 1, 1, 0);   // mismatched ungate
    add(1, 1, 6'h00, 0,  1, 6'h1A, 0, 1, 1, 0);   // gate while gated
    add(0, 0, 6'h00, 0,  1, 6'h1A, 0, 0, 1, 0);
    add(1, 0, 6'h1A, 0,  0, 6'h00, 0, 0, 0, 1);   // matching ungate -> WAKE
    for (int i = 0; i < 7; i++)
      add(1, 1, 6'h1A, 1,  0, 6'h00, 0, 0, 0, 1);
    add(1, 1, 6'h1A, 1,  0, 6'h00, 1, 0, 1, 0);   // done 8 cycles after pg_en fell
    add(1, 1, 6'h1A, 1,  0, 6'h00, 0, 0, 0, 1);   // held request accepted once ready
    add(0, 0, 6'h00, 0,  0, 6'h00, 0, 0, 0, 1);
    add(0, 0, 6'h00, 1,  1, 6'h1A, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 6'h00, 0, 0, 1, 0);
    @(negedge clk) rst = 1'b0;

    drive(1, 1, {3'd1, 3'd5}, 1); step(); chk_out("oob_x", 0, 6'h00, 0, 1, 1, 0);
    drive(1, 1, {3'd4, 3'd1}, 1); step(); chk_out("oob_y", 0, 6'h00, 0, 1, 1, 0);
    drive(1, 0, 6'h1A, 1);        step(); chk_out("ungate_idle", 0, 6'h00, 0, 1, 1, 0);
    drive(0, 0, 6'h00, 1);        step(); chk_out("err_once", 0, 6'h00, 0, 0, 1, 0);

    drive(1, 1, 6'h1A, 0); step(); chk_out("to_accept", 0, 6'h00, 0, 0, 0, 1);
    drive(0, 0, 6'h00, 0);
    for (int k = 1; k <= 64; k++) begin
      step();
      chk("to_pg_en", 32'(pg_en), 32'd0);
      chk($sformatf("to_err_c%0d", k), 32'(err), 32'(k == 64));
    end
    step(); chk_out("to_after", 0, 6'h00, 0, 0, 1, 0);

    // Reach GATED, then reset asynchronously.
    drive(1, 1, 6'h1A, 1); step();
    drive(0, 0, 6'h00, 1);
    for (int k = 0; k < 20 && !done; k++) step();
    chk("gated_done", 32'(done), 32'd1);
    chk("gated_pg_en", 32'(pg_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_gated_pg_en", 32'(pg_en), 32'd0);
    chk("rst_gated_pg_node", 32'(pg_node), 32'd0);
    chk("rst_gated_done", 32'(done), 32'd0);
    @(negedge clk) rst = 1'b0;
    drive(1, 1, 6'h09, 1); step(); chk_out("post_rst_accept", 0, 6'h00, 0, 0, 0, 1);
    drive(0, 0, 6'h00, 1); step(); chk_out("settle_09", 1, 6'h09, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_settle_pg_en", 32'(pg_en), 32'd0);
    chk("rst_settle_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;
    drive(0, 0, 6'h00, 1);
    step(); chk_out("rst_settle_idle", 0, 6'h00, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rst_no_done", 32'(done), 32'd0);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].g, vecs[i].n, vecs[i].idle);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].pe, vecs[i].pn, vecs[i].dn,
              vecs[i].er, vecs[i].rd, vecs[i].bs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
